// File: rtl/iiitb_usr_seq.sv
// Command sequencer for an 8-bit universal shift register: it loads a word,
// shifts it N times with a selectable serial fill, streams the bits shifted out and returns the final word.
module iiitb_usr_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [1:0]       cmd_fill,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_data_in,
  output logic             usr_sl_ser,
  output logic             usr_sr_ser,
  input  logic [WIDTH-1:0] usr_data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_LEFT  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LOAD  = 2'b10;
  localparam logic [1:0] SEL_HOLD  = 2'b11;

  localparam logic [1:0] FILL_ZERO = 2'b00;
  localparam logic [1:0] FILL_ONE  = 2'b01;
  localparam logic [1:0] FILL_PIN  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic shifting;
  logic ser_bit;
  logic fill_bit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 2'b00;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Held low during clear so a host never sees the sequencer as idle while reset is asserted.
  assign cmd_ready = (state_q == S_IDLE) && !clear;

  // NOTE: every variable gets its hold value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          fill_d  = cmd_fill;
          cnt_d   = (cmd_count > CNT_MAX) ? CNT_MAX : cmd_count;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = usr_data_out;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The outgoing bit is read live from the register, which also serves as the rotate feedback.
  always_comb begin
    shifting = (state_q == S_SHIFT);
    ser_bit  = dir_q ? usr_data_out[WIDTH-1] : usr_data_out[0];

    case (fill_q)
      FILL_ZERO: fill_bit = 1'b0;
      FILL_ONE:  fill_bit = 1'b1;
      FILL_PIN:  fill_bit = ser_in;
      default:   fill_bit = ser_bit;
    endcase

    case (state_q)
      S_LOAD:  usr_select = SEL_LOAD;
      S_SHIFT: usr_select = dir_q ? SEL_LEFT : SEL_RIGHT;
      default: usr_select = SEL_HOLD;
    endcase
  end

  assign ser_out     = shifting & ser_bit;
  assign ser_valid   = shifting;
  assign usr_sl_ser  = shifting & dir_q & fill_bit;
  assign usr_sr_ser  = shifting & ~dir_q & fill_bit;
  // data_q only changes on the accepting edge, so outside LOAD it still holds the last loaded word.
  assign usr_data_in = data_q;
  assign result      = result_q;
  assign done        = done_q;

endmodule

// File: tb/tb_iiitb_usr_seq.sv
// Directed bench for iiitb_usr_seq; a small behavioural universal shift
// register stands in for the iiitb_usr instance the sequencer drives.
module tb_iiitb_usr_seq;

  logic       clock;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic [1:0] cmd_fill;
  logic       ser_in;
  logic       ser_out;
  logic       ser_valid;
  logic       done;
  logic [7:0] result;
  logic [1:0] usr_select;
  logic [7:0] usr_data_in;
  logic       usr_sl_ser;
  logic       usr_sr_ser;
  logic [7:0] usr_data_out;

  int total = 0;
  int bad   = 0;

  iiitb_usr_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clock        (clock),
    .clear        (clear),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .cmd_dir      (cmd_dir),
    .cmd_count    (cmd_count),
    .cmd_fill     (cmd_fill),
    .ser_in       (ser_in),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .done         (done),
    .result       (result),
    .usr_select   (usr_select),
    .usr_data_in  (usr_data_in),
    .usr_sl_ser   (usr_sl_ser),
    .usr_sr_ser   (usr_sr_ser),
    .usr_data_out (usr_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Universal shift register: 00 left, 01 right, 10 load, 11 hold.
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      usr_data_out <= 8'h00;
    end else begin
      case (usr_select)
        2'b00:   usr_data_out <= {usr_data_out[6:0], usr_sl_ser};
        2'b01:   usr_data_out <= {usr_sr_ser, usr_data_out[7:1]};
        2'b10:   usr_data_out <= usr_data_in;
        default: usr_data_out <= usr_data_out;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic dir, input logic [3:0] cnt,
                       input logic [1:0] fill);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = cnt;
    cmd_fill  = fill;
  endtask

  // Called at a negedge with the command already on the inputs and the DUT idle.
  // bits[i] is the i-th bit expected on ser_out; n is the saturated count.
  task automatic run_cmd(input string name, input logic [7:0] d, input logic dir,
                         input int n, input logic [1:0] fill, input logic [15:0] bits,
                         input logic [7:0] res, input bit keep,
                         input logic [7:0] nd, input logic ndir, input logic [3:0] ncnt,
                         input logic [1:0] nfill);
    logic s;
    check({name, ".ready"}, cmd_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    if (keep) drive(nd, ndir, ncnt, nfill);
    else      cmd_valid = 1'b0;
    check({name, ".load_sel"}, usr_select, 2'b10);
    check({name, ".load_data"}, usr_data_in, d);
    check({name, ".load_busy"}, cmd_ready, 1'b0);
    check({name, ".load_done"}, done, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      case (fill)
        2'b00:   s = 1'b0;
        2'b01:   s = 1'b1;
        2'b10:   s = ser_in;
        default: s = bits[i];
      endcase
      check($sformatf("%s.sel%0d", name, i), usr_select, dir ? 2'b00 : 2'b01);
      check($sformatf("%s.sv%0d", name, i), ser_valid, 1'b1);
      check($sformatf("%s.so%0d", name, i), ser_out, bits[i]);
      check($sformatf("%s.sl%0d", name, i), usr_sl_ser, dir ? s : 1'b0);
      check($sformatf("%s.sr%0d", name, i), usr_sr_ser, dir ? 1'b0 : s);
    end
    @(negedge clock);
    check({name, ".dn_sel"}, usr_select, 2'b11);
    check({name, ".dn_sv"}, ser_valid, 1'b0);
    check({name, ".dn_early"}, done, 1'b0);
    @(negedge clock);
    check({name, ".done"}, done, 1'b1);
    check({name, ".result"}, result, res);
    check({name, ".ready_again"}, cmd_ready, 1'b1);
    check({name, ".hold_data"}, usr_data_in, d);
  endtask

  initial begin
    clear     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_dir   = 1'b0;
    cmd_count = 4'd0;
    cmd_fill  = 2'b00;
    ser_in    = 1'b0;

    @(negedge clock);
    @(negedge clock);
    check("rst.ready", cmd_ready, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.sv", ser_valid, 1'b0);
    check("rst.result", result, 8'h00);
    check("rst.sel", usr_select, 2'b11);
    check("rst.din", usr_data_in, 8'h00);
    check("rst.sl", usr_sl_ser, 1'b0);
    check("rst.sr", usr_sr_ser, 1'b0);
    clear = 1'b0;
    #1;
    check("idle.ready", cmd_ready, 1'b1);
    check("idle.sel", usr_select, 2'b11);

    // 0xAB right by 3, zero fill: out 1,1,0 -> 0x15
    @(negedge clock);
    drive(8'hAB, 1'b0, 4'd3, 2'b00);
    run_cmd("t1", 8'hAB, 1'b0, 3, 2'b00, 16'h0003, 8'h15, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);

    // 0xAB left by 4, one fill: out 1,0,1,0 -> 0xBF
    @(negedge clock);
    check("t1.done_pulse", done, 1'b0);
    check("t1.result_hold", result, 8'h15);
    drive(8'hAB, 1'b1, 4'd4, 2'b01);
    run_cmd("t2", 8'hAB, 1'b1, 4, 2'b01, 16'h0005, 8'hBF, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);

    // 0xAB rotate right by 8: out 1,1,0,1,0,1,0,1 -> 0xAB
    @(negedge clock);
    drive(8'hAB, 1'b0, 4'd8, 2'b11);
    run_cmd("t3", 8'hAB, 1'b0, 8, 2'b11, 16'h00AB, 8'hAB, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);

    // count 0: load only, done two cycles after accept
    @(negedge clock);
    drive(8'h5A, 1'b0, 4'd0, 2'b01);
    run_cmd("t4a", 8'h5A, 1'b0, 0, 2'b01, 16'h0000, 8'h5A, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);

    // count 12 saturates to 8: 0xC3 out LSB first 1,1,0,0,0,0,1,1 -> 0x00
    @(negedge clock);
    drive(8'hC3, 1'b0, 4'd12, 2'b00);
    run_cmd("t4b", 8'hC3, 1'b0, 8, 2'b00, 16'h00C3, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);

    // serial pin fill: 0x00 right by 2 with ser_in=1 -> 0xC0
    @(negedge clock);
    ser_in = 1'b1;
    drive(8'h00, 1'b0, 4'd2, 2'b10);
    run_cmd("tpin", 8'h00, 1'b0, 2, 2'b10, 16'h0000, 8'hC0, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);
    ser_in = 1'b0;

    // back-to-back with cmd_valid held: 0xF0 right 1 -> 0x78, then 0x0F left 2 -> 0x3C
    @(negedge clock);
    drive(8'hF0, 1'b0, 4'd1, 2'b00);
    run_cmd("t5a", 8'hF0, 1'b0, 1, 2'b00, 16'h0000, 8'h78, 1'b1, 8'h0F, 1'b1, 4'd2, 2'b00);
    run_cmd("t5b", 8'h0F, 1'b1, 2, 2'b00, 16'h0000, 8'h3C, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);
    @(negedge clock);
    check("t5.no_dup_ready", cmd_ready, 1'b1);
    check("t5.no_dup_sel", usr_select, 2'b11);

    // clear during the second SHIFT cycle aborts the command
    drive(8'hAB, 1'b0, 4'd4, 2'b00);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("t6.shift2", ser_valid, 1'b1);
    clear = 1'b1;
    drive(8'h33, 1'b1, 4'd1, 2'b01);
    #1;
    check("t6.sel", usr_select, 2'b11);
    check("t6.ready", cmd_ready, 1'b0);
    check("t6.sv", ser_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("t6.ready_clr%0d", i), cmd_ready, 1'b0);
      check($sformatf("t6.done_clr%0d", i), done, 1'b0);
    end
    clear     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("t6.ready_rel", cmd_ready, 1'b1);
    check("t6.result_clr", result, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("t6.no_done%0d", i), done, 1'b0);
    end

    // recovery: 0x81 left 1, zero fill: out 1 -> 0x02
    drive(8'h81, 1'b1, 4'd1, 2'b00);
    run_cmd("t6r", 8'h81, 1'b1, 1, 2'b00, 16'h0001, 8'h02, 1'b0, 8'h00, 1'b0, 4'd0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
